multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  opcode field, instr[31:26], taken from the datapath instruction register.
REQ-005 funct  input  6  function field, instr[5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 iord  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-008 memwrite  output  1  memory write enable.
REQ-009 irwrite  output  1  instruction register load enable.
REQ-010 regdst  output  1  register write destination: 0 = rt, 1 = rd.
REQ-011 memtoreg  output  1  register write data: 0 = ALU result register, 1 = memory data register.
REQ-012 regwrite  output  1  register file write enable.
REQ-013 alusrca  output  1  ALU A input: 0 = PC, 1 = register A.
REQ-014 alusrcb  output  2  ALU B input: 00 = register B, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
REQ-015 pcsrc  output  2  next-PC select: 00 = ALU output, 01 = ALU result register, 10 = jump target.
REQ-016 alucontrol  output  3  ALU operation, same encoding as the existing ALU.
REQ-017 pcen  output  1  PC register enable.
REQ-018 illegal_op  output  1  one-cycle flag: undefined opcode seen in DECODE.
REQ-019 state  output  4  current state encoding, for debug and verification.

Function
REQ-020 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-021 Transitions:
- FETCH -> DECODE.
- DECODE by op: lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP; any other op -> FETCH.
- MEMADR -> MEMRD on lw, MEMWR on sw.
- MEMRD -> MEMWB; EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
REQ-022 Outputs are a Moore decode of the state register only, except pcen. Every output not listed for a state SHALL be 0, never x.
REQ-023 Per-state asserted controls (internal aluop: 00 = add, 01 = sub, 10 = funct):
- FETCH: irwrite, pcwrite, alusrcb=01.
- DECODE: alusrcb=11.
- MEMADR and ADDIEX: alusrca, alusrcb=10.
- MEMRD: iord.
- MEMWB: memtoreg, regwrite.
- MEMWR: iord, memwrite.
- EXECUTE: alusrca, aluop=10.
- ALUWB: regdst, regwrite.
- BRANCH: alusrca, aluop=01, pcsrc=01, branch.
- ADDIWB: regwrite.
- JUMP: pcsrc=10, pcwrite.
REQ-024 pcen = pcwrite | (branch & zero); this is combinational on zero in the same cycle.
REQ-025 alucontrol: aluop 00 -> 010, 01 -> 110, 10 -> funct decode. The funct decode is add 010, sub 110, and 000, or 001, slt 111; an unknown funct gives 000.
REQ-026 Cycles per instruction: lw 5; sw, R-type, addi 4; beq, j 3; undefined op 2.
REQ-027 illegal_op is asserted only in DECODE, and only when op is undefined.

Reset
REQ-028 At a clk edge with reset=1, state loads FETCH; reset asserted mid-instruction aborts that instruction.
REQ-029 While reset=1, irwrite, pcen, regwrite and memwrite SHALL be forced to 0 combinationally; other outputs follow the FETCH decode.
REQ-030 The first FETCH after reset deasserts completes in one cycle with irwrite=pcen=1.

Configuration
REQ-031 Macro MULTICYCLE_BNE_EN, when defined, adds state BNE=12.
REQ-032 With the macro, op 000101 in DECODE -> BNE. BNE drives the BRANCH controls, except pcen = bne & ~zero; BNE -> FETCH.
REQ-033 Without the macro, op 000101 is undefined: illegal_op=1, DECODE -> FETCH, and state 12 is unreachable.

Structure
REQ-034 Package mc_pkg holds the state localparams, opcode constants (R-type, lw, sw, beq, addi, j, bne), aluop codes and alusrcb/pcsrc select codes.
REQ-035 The sole sub-module is the existing aludec, instantiated for the alucontrol decode; the state register and output decode are coded in multicycle_controller.

Verification
REQ-036 Reset held 2 cycles, then released -> state=0, pcen=irwrite=1, alusrcb=01, alucontrol=010 in the first cycle.
REQ-037 lw (op 100011) -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; iord=1 in state 3.
REQ-038 R-type sub (funct 100010) -> states 0,1,6,7,0; alucontrol=110 in state 6; regdst=regwrite=1 in state 7.
REQ-039 beq with zero=1 -> pcen=1, pcsrc=01 in state 8; with zero=0 -> pcen=0; the next state is 0 in both cases.
REQ-040 op 111111 -> illegal_op=1 for exactly one cycle in state 1, then state 0, with no regwrite or memwrite. Run with and without MULTICYCLE_BNE_EN, applying op 000101 in each case.
REQ-041 reset asserted while in state 5 (sw) -> state=0 at the next edge, and memwrite=0 in that cycle.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, ALU and mux select codes.
// Defining MULTICYCLE_BNE_EN adds the BNE state (12) for the bne instruction.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
`ifdef MULTICYCLE_BNE_EN
        , S_BNE   = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle; master is the controller, slave is the datapath.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal_op, state
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal_op, state
    );
endinterface

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps aluop and the R-type funct field onto the ALU control encoding.
import mc_pkg::*;

module aludec (
    input  logic [5:0] funct_i,
    input  logic [1:0] aluop_i,
    output logic [2:0] alucontrol_o
);
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    always_comb begin
        alucontrol_o = ALU_AND;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALU_ADD;
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alucontrol_o = ALU_ADD;
                    FN_SUB:  alucontrol_o = ALU_SUB;
                    FN_AND:  alucontrol_o = ALU_AND;
                    FN_OR:   alucontrol_o = ALU_OR;
                    FN_SLT:  alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_AND;
                endcase
            end
            default: alucontrol_o = ALU_AND;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main controller: Moore FSM plus aludec; pcen also folds in the zero flag.
// Optional MULTICYCLE_BNE_EN adds the bne instruction through state BNE.
import mc_pkg::*;

module multicycle_controller (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);
    state_t     state_q, state_d;
    logic [1:0] aluop;
    logic       pcwrite, branch, bne;
    logic       irwrite_raw, regwrite_raw, memwrite_raw;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        aluop          = ALUOP_ADD;
        pcwrite        = 1'b0;
        branch         = 1'b0;
        bne            = 1'b0;
        irwrite_raw    = 1'b0;
        regwrite_raw   = 1'b0;
        memwrite_raw   = 1'b0;
        bus.iord       = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = SRCB_REG;
        bus.pcsrc      = PCSRC_ALU;
        bus.illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
                bus.alusrcb = SRCB_FOUR;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                bus.alusrcb = SRCB_IMM_SH;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
                state_d     = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                memwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXECUTE: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_SUB;
                bus.pcsrc   = PCSRC_ALUOUT;
                branch      = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.pcsrc = PCSRC_JUMP;
                pcwrite   = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef MULTICYCLE_BNE_EN
            S_BNE: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_SUB;
                bus.pcsrc   = PCSRC_ALUOUT;
                bne         = 1'b1;
                state_d     = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural write strobes are held off while reset is high, independent of state.
    assign bus.irwrite  = irwrite_raw  & ~reset;
    assign bus.regwrite = regwrite_raw & ~reset;
    assign bus.memwrite = memwrite_raw & ~reset;
    assign bus.pcen     = (pcwrite | (branch & bus.zero) | (bne & ~bus.zero)) & ~reset;
    assign bus.state    = state_q;

    aludec u_aludec (
        .funct_i      (bus.funct),
        .aluop_i      (aluop),
        .alucontrol_o (bus.alucontrol)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against a per-instruction step model.
module tb_multicycle_controller;

`ifdef MULTICYCLE_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       pcen;
        logic       illegal_op;
    } obs_t;

    int   total = 0;
    int   bad   = 0;
    obs_t trace[$];

    function automatic obs_t sample();
        obs_t o;
        o.state      = bus.state;
        o.iord       = bus.iord;
        o.memwrite   = bus.memwrite;
        o.irwrite    = bus.irwrite;
        o.regdst     = bus.regdst;
        o.memtoreg   = bus.memtoreg;
        o.regwrite   = bus.regwrite;
        o.alusrca    = bus.alusrca;
        o.alusrcb    = bus.alusrcb;
        o.pcsrc      = bus.pcsrc;
        o.alucontrol = bus.alucontrol;
        o.pcen       = bus.pcen;
        o.illegal_op = bus.illegal_op;
        return o;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    // Cycles per instruction; 2 means the opcode is undefined in this build.
    function automatic int instr_len(input logic [5:0] op);
        case (op)
            6'b100011:                       return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010:            return 3;
            6'b000101:                       return BNE_EN ? 3 : 2;
            default:                         return 2;
        endcase
    endfunction

    // Expected outputs for cycle k of an instruction, from the per-state control table.
    function automatic obs_t model(input logic [5:0] op, input logic [5:0] funct,
                                  input logic zero, input int k);
        obs_t e = '0;
        e.alucontrol = 3'b010;
        if (k == 0) begin
            e.state = 4'd0; e.irwrite = 1'b1; e.pcen = 1'b1; e.alusrcb = 2'b01;
        end else if (k == 1) begin
            e.state = 4'd1; e.alusrcb = 2'b11; e.illegal_op = (instr_len(op) == 2);
        end else begin
            case (op)
                6'b100011, 6'b101011: begin
                    if (k == 2) begin
                        e.state = 4'd2; e.alusrca = 1'b1; e.alusrcb = 2'b10;
                    end else if (op == 6'b101011) begin
                        e.state = 4'd5; e.iord = 1'b1; e.memwrite = 1'b1;
                    end else if (k == 3) begin
                        e.state = 4'd3; e.iord = 1'b1;
                    end else begin
                        e.state = 4'd4; e.memtoreg = 1'b1; e.regwrite = 1'b1;
                    end
                end
                6'b000000: begin
                    if (k == 2) begin
                        e.state = 4'd6; e.alusrca = 1'b1; e.alucontrol = funct_alu(funct);
                    end else begin
                        e.state = 4'd7; e.regdst = 1'b1; e.regwrite = 1'b1;
                    end
                end
                6'b000100, 6'b000101: begin
                    e.state      = (op == 6'b000100) ? 4'd8 : 4'd12;
                    e.alusrca    = 1'b1;
                    e.pcsrc      = 2'b01;
                    e.alucontrol = 3'b110;
                    e.pcen       = (op == 6'b000100) ? zero : ~zero;
                end
                6'b001000: begin
                    if (k == 2) begin
                        e.state = 4'd9; e.alusrca = 1'b1; e.alusrcb = 2'b10;
                    end else begin
                        e.state = 4'd10; e.regwrite = 1'b1;
                    end
                end
                default: begin
                    e.state = 4'd11; e.pcsrc = 2'b10; e.pcen = 1'b1;
                end
            endcase
        end
        return e;
    endfunction

    // Entry: the next falling edge lies in a FETCH cycle. Exit: same, one instruction later.
    // zmode 0/1 holds zero at that value, 2 randomizes it every cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                             input int zmode, input string name);
        obs_t got, exp;
        int   n = instr_len(op);
        trace.delete();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.op    = op;
            bus.funct = funct;
            bus.zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            #1;
            got = sample();
            exp = model(op, funct, bus.zero, k);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s op=%b step%0d: got %h expected %h", name, op, k, got, exp);
            end
            trace.push_back(got);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.state !== 4'd0) begin
            bad++;
            $display("FAIL %s return_to_fetch: got state %0d expected 0", name, bus.state);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.op   = 6'b0;
        bus.funct = 6'b0;
        bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.state, bus.irwrite, bus.pcen, bus.regwrite, bus.memwrite} !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold: got st=%0d ir=%b pcen=%b rw=%b mw=%b expected 0,0,0,0,0",
                     bus.state, bus.irwrite, bus.pcen, bus.regwrite, bus.memwrite);
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus.state !== 4'd0) begin
            bad++; $display("FAIL reset_state: got %0d expected 0", bus.state);
        end
        total++;
        if ({bus.pcen, bus.irwrite} !== 2'b11) begin
            bad++; $display("FAIL reset_first_fetch: got pcen/irwrite %b expected 11", {bus.pcen, bus.irwrite});
        end
        total++;
        if (bus.alusrcb !== 2'b01 || bus.alucontrol !== 3'b010) begin
            bad++;
            $display("FAIL reset_fetch_alu: got srcb=%b ctl=%b expected 01 010", bus.alusrcb, bus.alucontrol);
        end
    endtask

    task automatic test_lw();
        logic [19:0] seq;
        run_instr(6'b100011, 6'($urandom), 2, "lw");
        seq = {trace[0].state, trace[1].state, trace[2].state, trace[3].state, trace[4].state};
        total++;
        if (seq !== 20'h01234) begin
            bad++; $display("FAIL lw_states: got %h expected 01234", seq);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({trace[i].regwrite, trace[i].memtoreg, trace[i].iord} !== {i == 4, i == 4, i == 3}) begin
                bad++;
                $display("FAIL lw_controls step%0d: got rw/mtr/iord %b%b%b", i,
                         trace[i].regwrite, trace[i].memtoreg, trace[i].iord);
            end
        end
    endtask

    task automatic test_rtype_sub();
        logic [15:0] seq;
        run_instr(6'b000000, 6'b100010, 2, "rsub");
        seq = {trace[0].state, trace[1].state, trace[2].state, trace[3].state};
        total++;
        if (seq !== 16'h0167) begin
            bad++; $display("FAIL rsub_states: got %h expected 0167", seq);
        end
        total++;
        if (trace[2].alucontrol !== 3'b110) begin
            bad++; $display("FAIL rsub_alucontrol: got %b expected 110", trace[2].alucontrol);
        end
        total++;
        if ({trace[3].regdst, trace[3].regwrite} !== 2'b11) begin
            bad++; $display("FAIL rsub_wb: got %b expected 11", {trace[3].regdst, trace[3].regwrite});
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            run_instr(6'b000100, 6'($urandom), z, "beq");
            total++;
            if ({trace[2].state, trace[2].pcen, trace[2].pcsrc} !== {4'd8, z[0], 2'b01}) begin
                bad++;
                $display("FAIL beq_zero%0d: got st=%0d pcen=%b pcsrc=%b expected 8 %b 01",
                         z, trace[2].state, trace[2].pcen, trace[2].pcsrc, z[0]);
            end
        end
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'($urandom), 2, "illegal");
        total++;
        if ({trace.size() == 2, trace[0].illegal_op, trace[1].illegal_op} !== 3'b101) begin
            bad++;
            $display("FAIL illegal_flag: got len=%0d flags=%b%b expected 2 01",
                     trace.size(), trace[0].illegal_op, trace[1].illegal_op);
        end
        total++;
        if ({trace[0].regwrite, trace[0].memwrite, trace[1].regwrite, trace[1].memwrite} !== 4'b0) begin
            bad++; $display("FAIL illegal_writes: got nonzero regwrite/memwrite");
        end
        run_instr(6'b000101, 6'($urandom), 2, "op000101");
        total++;
        if (trace[1].illegal_op !== !BNE_EN) begin
            bad++; $display("FAIL bne_illegal: got %b expected %b", trace[1].illegal_op, !BNE_EN);
        end
        total++;
        if (trace[trace.size() - 1].state !== (BNE_EN ? 4'd12 : 4'd1)) begin
            bad++; $display("FAIL bne_last_state: got %0d", trace[trace.size() - 1].state);
        end
    endtask

    task automatic test_reset_mid_sw();
        obs_t got, exp;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.op   = 6'b101011;
            bus.zero = 1'b0;
            #1;
            got = sample();
            exp = model(6'b101011, bus.funct, 1'b0, k);
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL sw_abort step%0d: got %h expected %h", k, got, exp);
            end
        end
        reset = 1'b1;
        #1;
        total++;
        if ({bus.state, bus.memwrite} !== {4'd5, 1'b0}) begin
            bad++;
            $display("FAIL sw_abort_force: got st=%0d mw=%b expected 5 0", bus.state, bus.memwrite);
        end
        @(posedge clk);
        #1;
        total++;
        if ({bus.state, bus.memwrite} !== {4'd0, 1'b0}) begin
            bad++;
            $display("FAIL sw_abort_state: got st=%0d mw=%b expected 0 0", bus.state, bus.memwrite);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[7]    = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                  6'b001000, 6'b000010, 6'b000101};
        logic [5:0] functs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] op, funct;
        for (int i = 0; i < 150; i++) begin
            int sel = $urandom_range(0, 7);
            op    = (sel == 7) ? 6'($urandom) : ops[sel];
            sel   = $urandom_range(0, 5);
            funct = (sel == 5) ? 6'($urandom) : functs[sel];
            run_instr(op, funct, 2, "random");
        end
    endtask

    initial begin
        test_reset();
        run_instr(6'b001000, 6'b0, 2, "first_addi");
        test_lw();
        test_rtype_sub();
        test_beq();
        test_illegal();
        test_reset_mid_sw();
        run_instr(6'b000010, 6'b0, 2, "after_abort_j");
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
